rx_fifo: RTL and testbench

Byte FIFO between the UART receiver and the MCU. It buffers received bytes, drops bytes that arrive with a framing error or while full, and raises sticky error flags until the MCU clears them. It drives the MCU's `emptyRx`, `fullRx` and `framing_error` inputs, and consumes the MCU's `rcv_deq` and `fix_error` strobes.

---
 rtl/rx_fifo.sv | 88 ++++++++
 tb/tb_rx_fifo.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - show-ahead receive byte FIFO with sticky framing/overrun flags
// Optional feature macro: RX_FIFO_OVERRUN_EN (builds the overrun_error flag)
module rx_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        rcv_data,
  input  logic                     data_ready,
  input  logic                     framing_error_in,
  input  logic                     rcv_deq,
  input  logic                     fix_error,
  output logic [DATA_W-1:0]        rx_data,
  output logic                     emptyRx,
  output logic                     fullRx,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     framing_error,
  output logic                     overrun_error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign emptyRx = (count == '0);
  assign fullRx  = (count == CW'(DEPTH));
  assign rx_data = mem[rd_ptr];

  // Full blocks the write even when a read happens in the same cycle.
  assign wr_en = data_ready & ~framing_error_in & ~fullRx;
  assign rd_en = rcv_deq & ~emptyRx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= rcv_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flags: a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      framing_error <= 1'b0;
    end else if (data_ready & framing_error_in) begin
      framing_error <= 1'b1;
    end else if (fix_error) begin
      framing_error <= 1'b0;
    end
  end

`ifdef RX_FIFO_OVERRUN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_error <= 1'b0;
    end else if (data_ready & ~framing_error_in & fullRx) begin
      overrun_error <= 1'b1;
    end else if (fix_error) begin
      overrun_error <= 1'b0;
    end
  end
`else
  assign overrun_error = 1'b0;
`endif

endmodule

// File: tb/tb_rx_fifo.sv
// tb/tb_rx_fifo.sv - randomized scenario bench for rx_fifo against a queue model
module tb_rx_fifo;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] rcv_data = '0;
  logic              data_ready = 1'b0;
  logic              framing_error_in = 1'b0;
  logic              rcv_deq = 1'b0;
  logic              fix_error = 1'b0;
  logic [DATA_W-1:0] rx_data;
  logic              emptyRx;
  logic              fullRx;
  logic [3:0]        count;
  logic              framing_error;
  logic              overrun_error;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq [$];
  bit         m_fe;
  bit         m_ov;

  rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .rcv_data(rcv_data), .data_ready(data_ready),
    .framing_error_in(framing_error_in), .rcv_deq(rcv_deq), .fix_error(fix_error),
    .rx_data(rx_data), .emptyRx(emptyRx), .fullRx(fullRx), .count(count),
    .framing_error(framing_error), .overrun_error(overrun_error)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; the queue model advances at the same edge.
  task automatic cyc(input bit dr, input bit fe, input logic [7:0] d, input bit deq, input bit fix);
    bit full_pre, empty_pre;
    data_ready = dr; framing_error_in = fe; rcv_data = d; rcv_deq = deq; fix_error = fix;
    @(posedge clk);
    full_pre  = (mq.size() == DEPTH);
    empty_pre = (mq.size() == 0);
    if (fix) begin m_fe = 0; m_ov = 0; end
    if (dr && fe) m_fe = 1;
`ifdef RX_FIFO_OVERRUN_EN
    if (dr && !fe && full_pre) m_ov = 1;
`endif
    if (deq && !empty_pre) void'(mq.pop_front());
    if (dr && !fe && !full_pre) mq.push_back(d);
    #1;
    data_ready = 0; framing_error_in = 0; rcv_deq = 0; fix_error = 0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mq.delete(); m_fe = 0; m_ov = 0;
    #2;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    cyc(1, 0, 8'h12, 0, 0);
    cyc(1, 0, 8'h34, 0, 0);
    cyc(1, 0, 8'h56, 0, 0);
    cyc(1, 1, 8'h99, 0, 0);
    total++;
    if (count !== 4'd3 || framing_error !== 1'b1) begin
      bad++; $display("FAIL pre_reset count=%0d fe=%0b expected count=3 fe=1", count, framing_error);
    end
    #2;
    reset = 1'b1;
    mq.delete(); m_fe = 0; m_ov = 0;
    #1;
    total++;
    if (count !== 4'd0 || emptyRx !== 1'b1 || fullRx !== 1'b0 || rx_data !== 8'h00 ||
        framing_error !== 1'b0 || overrun_error !== 1'b0) begin
      bad++;
      $display("FAIL reset_state count=%0d empty=%0b full=%0b rx=%h fe=%0b ov=%0b expected 0 1 0 00 0 0",
               count, emptyRx, fullRx, rx_data, framing_error, overrun_error);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_order();
    logic [7:0] v [3];
    v[0] = 8'hA5; v[1] = 8'h3C; v[2] = 8'h7E;
    for (int i = 0; i < 3; i++) cyc(1, 0, v[i], 0, 0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rx_data !== v[i] || emptyRx !== 1'b0) begin
        bad++; $display("FAIL order_%0d rx=%h empty=%0b expected %h 0", i, rx_data, emptyRx, v[i]);
      end
      cyc(0, 0, 8'h00, 1, 0);
    end
    total++;
    if (emptyRx !== 1'b1 || count !== 4'd0) begin
      bad++; $display("FAIL order_empty empty=%0b count=%0d expected 1 0", emptyRx, count);
    end
  endtask

  task automatic test_fill_overrun();
    bit exp_ov;
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 8'(i), 0, 0);
    total++;
    if (fullRx !== 1'b1 || count !== 4'd8) begin
      bad++; $display("FAIL fill full=%0b count=%0d expected 1 8", fullRx, count);
    end
    cyc(1, 0, 8'hFF, 0, 0);
`ifdef RX_FIFO_OVERRUN_EN
    exp_ov = 1'b1;
`else
    exp_ov = 1'b0;
`endif
    total++;
    if (count !== 4'd8 || overrun_error !== exp_ov || overrun_error !== m_ov) begin
      bad++; $display("FAIL overrun count=%0d ov=%0b expected 8 %0b", count, overrun_error, exp_ov);
    end
    // Full plus simultaneous push/pop: push is still refused.
    cyc(1, 0, 8'hEE, 1, 0);
    total++;
    if (count !== 4'd7 || rx_data !== 8'h01) begin
      bad++; $display("FAIL full_pushpop count=%0d rx=%h expected 7 01", count, rx_data);
    end
    for (int i = 1; i < DEPTH; i++) begin
      total++;
      if (rx_data !== 8'(i)) begin
        bad++; $display("FAIL drain_%0d rx=%h expected %h", i, rx_data, 8'(i));
      end
      cyc(0, 0, 8'h00, 1, 0);
    end
    total++;
    if (emptyRx !== 1'b1) begin
      bad++; $display("FAIL drain_empty empty=%0b expected 1", emptyRx);
    end
    cyc(0, 0, 8'h00, 0, 1);
    total++;
    if (overrun_error !== 1'b0) begin
      bad++; $display("FAIL overrun_clear ov=%0b expected 0", overrun_error);
    end
  endtask

  task automatic test_framing();
    cyc(1, 0, 8'h22, 0, 0);
    cyc(1, 1, 8'h11, 0, 0);
    total++;
    if (count !== 4'd1 || framing_error !== 1'b1 || rx_data !== 8'h22) begin
      bad++; $display("FAIL framing_set count=%0d fe=%0b rx=%h expected 1 1 22", count, framing_error, rx_data);
    end
    cyc(1, 1, 8'h33, 0, 1);
    total++;
    if (framing_error !== 1'b1 || count !== 4'd1) begin
      bad++; $display("FAIL framing_set_wins fe=%0b count=%0d expected 1 1", framing_error, count);
    end
    cyc(0, 0, 8'h00, 0, 1);
    total++;
    if (framing_error !== 1'b0) begin
      bad++; $display("FAIL framing_clear fe=%0b expected 0", framing_error);
    end
    cyc(0, 0, 8'h00, 1, 0);
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) cyc(1, 0, 8'h40 + 8'(i), 0, 0);
    cyc(1, 0, 8'h4F, 1, 0);
    total++;
    if (count !== 4'd4 || rx_data !== 8'h41) begin
      bad++; $display("FAIL pushpop_mid count=%0d rx=%h expected 4 41", count, rx_data);
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, 1, 0);
    cyc(1, 0, 8'hC3, 1, 0);
    total++;
    if (count !== 4'd1 || rx_data !== 8'hC3 || emptyRx !== 1'b0) begin
      bad++; $display("FAIL pushpop_empty count=%0d rx=%h empty=%0b expected 1 c3 0", count, rx_data, emptyRx);
    end
    cyc(0, 0, 8'h00, 1, 0);
  endtask

  task automatic test_wrap_stray();
    logic [7:0] d;
    do_reset();
    cyc(0, 0, 8'h00, 1, 0);
    total++;
    if (count !== 4'd0 || emptyRx !== 1'b1 || fullRx !== 1'b0 || rx_data !== 8'h00 ||
        framing_error !== 1'b0 || overrun_error !== 1'b0) begin
      bad++; $display("FAIL stray_pop count=%0d empty=%0b rx=%h fe=%0b ov=%0b expected 0 1 00 0 0",
                      count, emptyRx, rx_data, framing_error, overrun_error);
    end
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      cyc(1, 0, d, 0, 0);
      total++;
      if (rx_data !== d || count !== 4'd1) begin
        bad++; $display("FAIL wrap_%0d rx=%h count=%0d expected %h 1", i, rx_data, count, d);
      end
      cyc(0, 0, 8'h00, 1, 0);
    end
    cyc(0, 0, 8'h00, 1, 0);
    total++;
    if (count !== 4'd0 || emptyRx !== 1'b1 || framing_error !== 1'b0 || overrun_error !== 1'b0) begin
      bad++; $display("FAIL wrap_stray count=%0d empty=%0b expected 0 1", count, emptyRx);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 8, 8'($urandom),
          $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 5);
      total++;
      if (count !== 4'(mq.size()) || emptyRx !== (mq.size() == 0) || fullRx !== (mq.size() == DEPTH) ||
          framing_error !== m_fe || overrun_error !== m_ov ||
          (mq.size() != 0 && rx_data !== mq[0])) begin
        bad++;
        if (errs++ < 10)
          $display("FAIL random_%0d count=%0d empty=%0b full=%0b rx=%h fe=%0b ov=%0b expected count=%0d fe=%0b ov=%0b head=%h",
                   i, count, emptyRx, fullRx, rx_data, framing_error, overrun_error,
                   mq.size(), m_fe, m_ov, (mq.size() != 0) ? mq[0] : 8'h00);
      end
    end
  endtask

  initial begin
    m_fe = 0; m_ov = 0;
    #12;
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_order();
    test_fill_overrun();
    test_framing();
    test_simultaneous();
    test_wrap_stray();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
